// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: decodes CPU strobes onto BRAM/text/PSRAM, waits for ready, reports unmapped or timed-out accesses
module periph_bus_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stb,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_done,
   output logic        o_err,
   output logic        o_busy,
   output logic [2:0]  o_sel,
   output logic        o_p_stb,
   output logic        o_p_we,
   output logic [23:0] o_p_addr,
   output logic [31:0] o_p_wdata,
   input  logic [7:0]  i_bram_rdata,
   input  logic [7:0]  i_text_rdata,
   input  logic [15:0] i_psram_rdata,
   input  logic [2:0]  i_p_ready
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_text, is_bram, is_psram;
   logic [2:0]       dec_sel, hit;
   logic [31:0]      cap;
   // address decode (text window has priority over bram) and read-data capture mux
   always_comb begin
      is_text  = i_addr[31:7] == 25'h00001FE;
      is_bram  = i_addr[31:16] == 16'h0000 && !is_text;
      is_psram = i_addr[31:23] == 9'h080;
      dec_sel  = {is_psram, is_text, is_bram};
      hit      = i_p_ready & o_sel;
      cap      = o_p_we   ? 32'h0 :
                 o_sel[2] ? {16'h0, i_psram_rdata} :
                 o_sel[1] ? {24'h0, i_text_rdata} : {24'h0, i_bram_rdata};
   end
   assign o_busy = state != IDLE;
   // transaction sequencer: accept, strobe peripheral, wait for ready or timeout, pulse done
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         o_rdata   <= '0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         o_sel     <= '0;
         o_p_stb   <= 1'b0;
         o_p_we    <= 1'b0;
         o_p_addr  <= '0;
         o_p_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (i_stb) begin
               o_p_we    <= i_we;
               o_p_addr  <= i_addr[23:0];
               o_p_wdata <= i_wdata;
               o_sel     <= dec_sel;
               if (|dec_sel) begin
                  state   <= ISSUE;
                  o_p_stb <= 1'b1;
               end else begin
                  state  <= DONE;
                  o_done <= 1'b1;
                  o_err  <= 1'b1;
               end
            end
            ISSUE: begin
               o_p_stb <= 1'b0;
               cnt     <= '0;
               state   <= WAIT;
            end
            WAIT: if (|hit) begin
               o_rdata <= cap;
               o_done  <= 1'b1;
               state   <= DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               o_done <= 1'b1;
               o_err  <= 1'b1;
               state  <= DONE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               o_done  <= 1'b0;
               o_err   <= 1'b0;
               o_rdata <= '0;
               o_sel   <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
